display_multiplexado_7seg: RTL

Scanned driver for the shared 4-digit 7-segment display, downstream of the bottling/cork control datapath. Takes two binary counts, the bottle count and the secondary cork-buffer count, each 0..99 nominal. Converts them to BCD with a sequential double-dabble engine and time-multiplexes four active-low digits. Updates both values atomically once per scan frame, so a digit never shows a half-updated value.

---
 rtl/display_pkg.sv | 59 +++++
 rtl/bin7_to_bcd_seq.sv | 98 +++++++++
 rtl/display_multiplexado_7seg.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : display_pkg
//  Purpose  : Shared definitions for the multiplexed 7-segment display driver:
//             internal digit codes, active-low segment patterns
//             (bit7=a .. bit1=g, bit0=dp), the converter FSM state type and
//             the code-to-segment lookup.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package display_pkg;

  // Digit codes beyond 0..9 used by the display registers
  localparam logic [3:0] DIG_BLANK = 4'hA;
  localparam logic [3:0] DIG_DASH  = 4'hB;

  // Active-low segment patterns, dp always off (bit0 = 1)
  localparam logic [7:0] SEG_0     = 8'h03;
  localparam logic [7:0] SEG_1     = 8'h9F;
  localparam logic [7:0] SEG_2     = 8'h25;
  localparam logic [7:0] SEG_3     = 8'h0D;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h49;
  localparam logic [7:0] SEG_6     = 8'h41;
  localparam logic [7:0] SEG_7     = 8'h1F;
  localparam logic [7:0] SEG_8     = 8'h01;
  localparam logic [7:0] SEG_9     = 8'h09;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hFD;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } conv_state_e;

  // Unknown codes fall back to blank so a corrupted register never lights
  // a random pattern.
  function automatic logic [7:0] seg_of(input logic [3:0] code);
    logic [7:0] s;
    case (code)
      4'd0:     s = SEG_0;
      4'd1:     s = SEG_1;
      4'd2:     s = SEG_2;
      4'd3:     s = SEG_3;
      4'd4:     s = SEG_4;
      4'd5:     s = SEG_5;
      4'd6:     s = SEG_6;
      4'd7:     s = SEG_7;
      4'd8:     s = SEG_8;
      4'd9:     s = SEG_9;
      DIG_DASH: s = SEG_DASH;
      default:  s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin7_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : bin7_to_bcd_seq
//  Purpose  : Sequential double-dabble converter, 7-bit binary to two BCD
//             nibbles in 7 cycles. Also flags inputs above 99, which cannot
//             be represented in two digits.
//  Ports    : clk      - clock
//             clr      - asynchronous active-low reset (aborts conversion)
//             start_i  - one-cycle pulse, samples bin_i
//             bin_i    - binary input 0..127
//             busy_o   - conversion in progress
//             done_o   - one-cycle pulse when tens_o/units_o are valid
//             tens_o   - BCD tens digit
//             units_o  - BCD units digit
//             ovf_o    - sampled value was greater than 99
//  Revision : 1.0 - initial release
// ============================================================================
module bin7_to_bcd_seq (
  input  logic       clk,
  input  logic       clr,
  input  logic       start_i,
  input  logic [6:0] bin_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [3:0] tens_o,
  output logic [3:0] units_o,
  output logic       ovf_o
);

  logic [6:0] sh_q,    sh_d;
  logic [3:0] tens_q,  tens_d;
  logic [3:0] units_q, units_d;
  logic [2:0] step_q,  step_d;
  logic       busy_q,  busy_d;
  logic       done_q,  done_d;
  logic       ovf_q,   ovf_d;
  logic [3:0] tens_adj, units_adj;

  always_comb begin
    // add-3 correction is applied before every shift
    tens_adj  = (tens_q  >= 4'd5) ? tens_q  + 4'd3 : tens_q;
    units_adj = (units_q >= 4'd5) ? units_q + 4'd3 : units_q;

    sh_d    = sh_q;
    tens_d  = tens_q;
    units_d = units_q;
    step_d  = step_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;

    if (start_i) begin
      sh_d    = bin_i;
      tens_d  = 4'd0;
      units_d = 4'd0;
      step_d  = 3'd0;
      busy_d  = 1'b1;
      ovf_d   = (bin_i > 7'd99);
    end else if (busy_q) begin
      tens_d  = {tens_adj[2:0], units_adj[3]};
      units_d = {units_adj[2:0], sh_q[6]};
      sh_d    = {sh_q[5:0], 1'b0};
      step_d  = step_q + 3'd1;
      if (step_q == 3'd6) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sh_q    <= '0;
      tens_q  <= '0;
      units_q <= '0;
      step_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sh_q    <= sh_d;
      tens_q  <= tens_d;
      units_q <= units_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign tens_o  = tens_q;
  assign units_o = units_q;
  assign ovf_o   = ovf_q;

endmodule
`default_nettype wire

// File: rtl/display_multiplexado_7seg.sv
`default_nettype none
// ============================================================================
//  Module   : display_multiplexado_7seg
//  Purpose  : Scanned driver for a 4-digit active-low 7-segment display.
//             Shows valor_a on digits 0/1 and valor_b on digits 2/3. Both
//             values are sampled when the scan enters digit 3, converted to
//             BCD, and committed together at the frame wrap.
//  Ports    : clk        - system clock
//             clr        - asynchronous active-low reset
//             valor_a    - bottle count (binary, 7 bit)
//             valor_b    - cork count (binary, 7 bit)
//             seg        - segments, active-low, bit7=a .. bit1=g, bit0=dp
//             an         - digit enables, active-low, bit0 = digit 0
//             frame_done - one-cycle pulse when new values are committed
//  Params   : SCAN_DIV   - clk cycles per digit slot (>= 16)
//             BLANK_ZERO - 1: blank a zero tens digit
//  Revision : 1.0 - initial release
// ============================================================================
module display_multiplexado_7seg
  import display_pkg::*;
#(
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_ZERO = 1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [6:0] valor_a,
  input  logic [6:0] valor_b,
  output logic [7:0] seg,
  output logic [3:0] an,
  output logic       frame_done
);

  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    dig_q, dig_d;
  logic          tc;
  conv_state_e   state_q, state_d;
  logic          start, commit;
  logic [3:0]    disp_q [4];
  logic [3:0]    disp_d [4];
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    an_q,  an_d;
  logic          frame_done_q;

  logic       busy_a, done_a, ovf_a;
  logic       busy_b, done_b, ovf_b;
  logic [3:0] tens_a, units_a, tens_b, units_b;
  logic [3:0] code_ta, code_ua, code_tb, code_ub;

  // ---------------------------------------------------------------- scan
  assign tc = (cnt_q == CW'(SCAN_DIV - 1));

  always_comb begin
    cnt_d = tc ? '0 : cnt_q + 1'b1;
    dig_d = tc ? dig_q + 2'd1 : dig_q;
    // All digits off for the first cycle of every slot (anti-ghosting);
    // otherwise the slot's own digit, which keeps dig_q until the wrap.
    an_d  = tc ? 4'hF : ~(4'b0001 << dig_q);
  end

  // ----------------------------------------------------------- converters
  bin7_to_bcd_seq u_conv_a (
    .clk     (clk),
    .clr     (clr),
    .start_i (start),
    .bin_i   (valor_a),
    .busy_o  (busy_a),
    .done_o  (done_a),
    .tens_o  (tens_a),
    .units_o (units_a),
    .ovf_o   (ovf_a)
  );

  bin7_to_bcd_seq u_conv_b (
    .clk     (clk),
    .clr     (clr),
    .start_i (start),
    .bin_i   (valor_b),
    .busy_o  (busy_b),
    .done_o  (done_b),
    .tens_o  (tens_b),
    .units_o (units_b),
    .ovf_o   (ovf_b)
  );

  // ------------------------------------------------------------------ FSM
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        // sample on the edge that moves the scan into digit 3
        if (tc && dig_q == 2'd2) begin
          start   = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        if (done_a && done_b && !busy_a && !busy_b) state_d = DONE;
      end
      DONE: begin
        if (tc && dig_q == 2'd3) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------- code select
  always_comb begin
    code_ta = ovf_a ? DIG_DASH :
              ((BLANK_ZERO != 0) && tens_a == 4'd0) ? DIG_BLANK : tens_a;
    code_ua = ovf_a ? DIG_DASH : units_a;
    code_tb = ovf_b ? DIG_DASH :
              ((BLANK_ZERO != 0) && tens_b == 4'd0) ? DIG_BLANK : tens_b;
    code_ub = ovf_b ? DIG_DASH : units_b;

    for (int i = 0; i < 4; i++) disp_d[i] = disp_q[i];
    if (commit) begin
      disp_d[0] = code_ta;
      disp_d[1] = code_ua;
      disp_d[2] = code_tb;
      disp_d[3] = code_ub;
    end

    // look up the post-edge digit so seg tracks an without a cycle of lag
    seg_d = seg_of(disp_d[dig_d]);
  end

  // ------------------------------------------------------------ registers
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt_q        <= '0;
      dig_q        <= 2'd0;
      state_q      <= IDLE;
      disp_q[0]    <= DIG_BLANK;
      disp_q[1]    <= DIG_BLANK;
      disp_q[2]    <= DIG_BLANK;
      disp_q[3]    <= DIG_BLANK;
      seg_q        <= SEG_BLANK;
      an_q         <= 4'hF;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      dig_q        <= dig_d;
      state_q      <= state_d;
      disp_q[0]    <= disp_d[0];
      disp_q[1]    <= disp_d[1];
      disp_q[2]    <= disp_d[2];
      disp_q[3]    <= disp_d[3];
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= commit;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire
